// File: rtl/adc_sample_aligner.sv
// Time-interleaved ADC frame aligner: per-channel offset correction with saturation,
// lane rotation, and a frame FIFO carrying a sequence tag and a sticky overflow flag.
module adc_sample_aligner #(
    parameter int ADC_BITS   = 9,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic [ADC_BITS-1:0]   ADCIN0,
    input  logic [ADC_BITS-1:0]   ADCIN1,
    input  logic [ADC_BITS-1:0]   ADCIN2,
    input  logic [ADC_BITS-1:0]   ADCIN3,
    input  logic [ADC_BITS-1:0]   ADCIN4,
    input  logic [ADC_BITS-1:0]   ADCIN5,
    input  logic [ADC_BITS-1:0]   ADCIN6,
    input  logic [ADC_BITS-1:0]   ADCIN7,
    input  logic                  EN,
    input  logic [2:0]            ROT,
    input  logic [7:0]            OFS0,
    input  logic [7:0]            OFS1,
    input  logic [7:0]            OFS2,
    input  logic [7:0]            OFS3,
    input  logic [7:0]            OFS4,
    input  logic [7:0]            OFS5,
    input  logic [7:0]            OFS6,
    input  logic [7:0]            OFS7,
    output logic [8*ADC_BITS-1:0] OUT_DATA,
    output logic [7:0]            OUT_TAG,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic                  OVF,
    input  logic                  CLR_OVF
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW    = ((ADC_BITS > 8) ? ADC_BITS : 8) + 2;
    localparam logic [PTR_W:0]         DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic signed [CW-1:0]   CODE_MAX  = CW'((2 ** ADC_BITS) - 1);

    logic [ADC_BITS-1:0] adc_in [8];
    logic [7:0]          ofs_in [8];

    assign adc_in[0] = ADCIN0;
    assign adc_in[1] = ADCIN1;
    assign adc_in[2] = ADCIN2;
    assign adc_in[3] = ADCIN3;
    assign adc_in[4] = ADCIN4;
    assign adc_in[5] = ADCIN5;
    assign adc_in[6] = ADCIN6;
    assign adc_in[7] = ADCIN7;
    assign ofs_in[0] = OFS0;
    assign ofs_in[1] = OFS1;
    assign ofs_in[2] = OFS2;
    assign ofs_in[3] = OFS3;
    assign ofs_in[4] = OFS4;
    assign ofs_in[5] = OFS5;
    assign ofs_in[6] = OFS6;
    assign ofs_in[7] = OFS7;

    // stage 1: capture registers
    logic                 s1_valid;
    logic [ADC_BITS-1:0]  s1_adc [8];
    logic signed [7:0]    s1_ofs [8];
    logic [2:0]           s1_rot;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            s1_valid <= 1'b0;
            s1_rot   <= '0;
            for (int unsigned k = 0; k < 8; k++) begin
                s1_adc[k] <= '0;
                s1_ofs[k] <= '0;
            end
        end else begin
            s1_valid <= EN;
            if (EN) begin
                s1_rot <= ROT;
                for (int unsigned k = 0; k < 8; k++) begin
                    s1_adc[k] <= adc_in[k];
                    s1_ofs[k] <= ofs_in[k];
                end
            end
        end
    end

    // stage 2: offset correction, saturation and lane rotation
    logic signed [CW-1:0]  diff [8];
    logic [ADC_BITS-1:0]   corr [8];
    logic [8*ADC_BITS-1:0] aligned;

    always_comb begin
        for (int unsigned k = 0; k < 8; k++) begin
            diff[k] = $signed(CW'(s1_adc[k])) - CW'(s1_ofs[k]);
            if (diff[k] < 0)
                corr[k] = '0;
            else if (diff[k] > CODE_MAX)
                corr[k] = '1;
            else
                corr[k] = diff[k][ADC_BITS-1:0];
        end
    end

    always_comb begin
        aligned = '0;
        for (int unsigned k = 0; k < 8; k++)
            aligned[k*ADC_BITS +: ADC_BITS] = corr[s1_rot + 3'(k)];
    end

    logic                  s2_valid;
    logic [8*ADC_BITS-1:0] s2_data;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid)
                s2_data <= aligned;
        end
    end

    // output FIFO; the tag is taken from the frame counter at the push edge
    logic [8*ADC_BITS-1:0] mem_data [FIFO_DEPTH];
    logic [7:0]            mem_tag  [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W:0]        count;
    logic [7:0]            frame_cnt;
    logic                  full;
    logic                  pop;
    logic                  push;
    logic                  drop;

    assign full = (count == DEPTH_CNT);
    assign pop  = OUT_VALID && OUT_READY;
    // a full FIFO still accepts a frame when the head leaves on the same edge
    assign push = s2_valid && (!full || pop);
    assign drop = s2_valid && full && !pop;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            frame_cnt <= '0;
            OVF       <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)
                count <= count + (PTR_W + 1)'(1);
            else if (pop && !push)
                count <= count - (PTR_W + 1)'(1);
            if (s2_valid)
                frame_cnt <= frame_cnt + 8'd1;
            if (drop)
                OVF <= 1'b1;
            else if (CLR_OVF)
                OVF <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_data[wr_ptr] <= s2_data;
            mem_tag[wr_ptr]  <= frame_cnt;
        end
    end

    assign OUT_VALID = (count != '0);
    assign OUT_DATA  = OUT_VALID ? mem_data[rd_ptr] : '0;
    assign OUT_TAG   = OUT_VALID ? mem_tag[rd_ptr]  : '0;

endmodule

// File: tb/tb_adc_sample_aligner.sv
// Directed bench for adc_sample_aligner: single-frame vector table, then
// backpressure/overflow, CLR_OVF priority and mid-stream reset sequences.
module tb_adc_sample_aligner;

    localparam int AB = 9;

    typedef struct {
        logic [2:0]           rot;
        logic [7:0][AB-1:0]   adc;
        logic [7:0][7:0]      ofs;
        logic [7:0][AB-1:0]   exp;
    } vec_t;

    logic                CLK = 1'b0;
    logic                RSTN = 1'b0;
    logic [7:0][AB-1:0]  cur_adc = '0;
    logic [7:0][7:0]     cur_ofs = '0;
    logic                EN = 1'b0;
    logic [2:0]          ROT = '0;
    logic [8*AB-1:0]     OUT_DATA;
    logic [7:0]          OUT_TAG;
    logic                OUT_VALID;
    logic                OUT_READY = 1'b0;
    logic                OVF;
    logic                CLR_OVF = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t vecs [4];

    adc_sample_aligner #(.ADC_BITS(AB), .FIFO_DEPTH(4)) dut (
        .CLK(CLK), .RSTN(RSTN),
        .ADCIN0(cur_adc[0]), .ADCIN1(cur_adc[1]), .ADCIN2(cur_adc[2]), .ADCIN3(cur_adc[3]),
        .ADCIN4(cur_adc[4]), .ADCIN5(cur_adc[5]), .ADCIN6(cur_adc[6]), .ADCIN7(cur_adc[7]),
        .EN(EN), .ROT(ROT),
        .OFS0(cur_ofs[0]), .OFS1(cur_ofs[1]), .OFS2(cur_ofs[2]), .OFS3(cur_ofs[3]),
        .OFS4(cur_ofs[4]), .OFS5(cur_ofs[5]), .OFS6(cur_ofs[6]), .OFS7(cur_ofs[7]),
        .OUT_DATA(OUT_DATA), .OUT_TAG(OUT_TAG), .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY), .OVF(OVF), .CLR_OVF(CLR_OVF)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        EN = 1'b0;
        OUT_READY = 1'b0;
        CLR_OVF = 1'b0;
        RSTN = 1'b0;
        tick();
        tick();
        RSTN = 1'b1;
    endtask

    task automatic load_vec(input int i);
        ROT     = vecs[i].rot;
        cur_adc = vecs[i].adc;
        cur_ofs = vecs[i].ofs;
    endtask

    initial begin
        int n;
        logic [7:0] exp_tags [5];

        vecs[0].rot = 3'd0;
        vecs[0].adc = {9'd70, 9'd60, 9'd50, 9'd40, 9'd30, 9'd20, 9'd10, 9'd0};
        vecs[0].ofs = '0;
        vecs[0].exp = {9'd70, 9'd60, 9'd50, 9'd40, 9'd30, 9'd20, 9'd10, 9'd0};
        vecs[1].rot = 3'd5;
        vecs[1].adc = {9'd510, 9'd60, 9'd50, 9'd40, 9'd30, 9'd3, 9'd10, 9'd0};
        vecs[1].ofs = {8'hFC, 8'h00, 8'h00, 8'h00, 8'h00, 8'h08, 8'h00, 8'h00};
        vecs[1].exp = {9'd40, 9'd30, 9'd0, 9'd10, 9'd0, 9'd511, 9'd60, 9'd50};
        vecs[2].rot = 3'd3;
        vecs[2].adc = {8{9'd100}};
        vecs[2].ofs = {8'h9C, 8'h32, 8'h00, 8'hFF, 8'h63, 8'h64, 8'h7F, 8'h80};
        vecs[2].exp = {9'd0, 9'd0, 9'd228, 9'd200, 9'd50, 9'd100, 9'd101, 9'd1};
        vecs[3].rot = 3'd7;
        vecs[3].adc = {9'd7, 9'd450, 9'd256, 9'd255, 9'd1, 9'd0, 9'd500, 9'd511};
        vecs[3].ofs = {8'h07, 8'hC3, 8'h80, 8'h7F, 8'hFF, 8'h00, 8'h0C, 8'hFF};
        vecs[3].exp = {9'd511, 9'd384, 9'd128, 9'd2, 9'd0, 9'd488, 9'd511, 9'd0};

        #2;
        check("reset_valid", 72'(OUT_VALID), 72'd0);
        check("reset_ovf", 72'(OVF), 72'd0);
        check("reset_data", 72'(OUT_DATA), 72'd0);
        check("reset_tag", 72'(OUT_TAG), 72'd0);
        do_reset();

        // single frames; inputs are scrambled after capture to prove stage 1 holds them
        OUT_READY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            load_vec(i);
            EN = 1'b1;
            tick();
            EN = 1'b0;
            cur_adc = {8{9'h1A5}};
            cur_ofs = {8{8'h5A}};
            ROT = 3'd2;
            tick();
            check("latency_not_early", 72'(OUT_VALID), 72'd0);
            tick();
            check("vec_valid", 72'(OUT_VALID), 72'd1);
            check("vec_data", 72'(OUT_DATA), 72'(vecs[i].exp));
            check("vec_tag", 72'(OUT_TAG), 72'(i));
            tick();
            check("vec_popped", 72'(OUT_VALID), 72'd0);
        end

        // backpressure, overflow, full push+pop and drain
        do_reset();
        load_vec(0);
        EN = 1'b1;
        repeat (6) tick();
        check("bp_full_no_ovf", 72'(OVF), 72'd0);
        check("bp_head_tag", 72'(OUT_TAG), 72'd0);
        tick();
        check("bp_ovf_set", 72'(OVF), 72'd1);
        check("bp_head_hold", 72'(OUT_TAG), 72'd0);
        check("bp_data_hold", 72'(OUT_DATA), 72'(vecs[0].exp));
        repeat (2) tick();
        OUT_READY = 1'b1;
        exp_tags = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd7};
        for (int i = 0; i < 5; i++) begin
            check("bp_pop_valid", 72'(OUT_VALID), 72'd1);
            check("bp_pop_tag", 72'(OUT_TAG), 72'(exp_tags[i]));
            tick();
        end
        CLR_OVF = 1'b1;
        tick();
        CLR_OVF = 1'b0;
        check("clr_no_drop", 72'(OVF), 72'd0);
        for (int i = 0; i < 4; i++) begin
            check("full_pp_tag", 72'(OUT_TAG), 72'(9 + i));
            check("full_pp_ovf", 72'(OVF), 72'd0);
            tick();
        end
        EN = 1'b0;
        n = 0;
        while (OUT_VALID && n < 20) begin
            check("drain_tag", 72'(OUT_TAG), 72'(13 + n));
            n++;
            tick();
        end
        check("drain_count", 72'(n), 72'd6);

        // CLR_OVF loses to a drop in the same cycle
        do_reset();
        load_vec(1);
        EN = 1'b1;
        repeat (7) tick();
        check("prio_ovf_set", 72'(OVF), 72'd1);
        CLR_OVF = 1'b1;
        tick();
        check("prio_clr_vs_drop", 72'(OVF), 72'd1);
        EN = 1'b0;
        CLR_OVF = 1'b0;
        repeat (3) tick();
        check("prio_sticky", 72'(OVF), 72'd1);
        CLR_OVF = 1'b1;
        tick();
        CLR_OVF = 1'b0;
        check("prio_cleared", 72'(OVF), 72'd0);
        check("prio_head_kept", 72'(OUT_TAG), 72'd0);
        check("prio_data_kept", 72'(OUT_DATA), 72'(vecs[1].exp));
        OUT_READY = 1'b1;
        n = 0;
        while (OUT_VALID && n < 20) begin
            check("prio_drain_tag", 72'(OUT_TAG), 72'(n));
            n++;
            tick();
        end
        check("prio_drain_count", 72'(n), 72'd4);

        // reset mid-stream with 3 queued and 2 in flight
        do_reset();
        load_vec(2);
        EN = 1'b1;
        repeat (5) tick();
        check("mid_pre_valid", 72'(OUT_VALID), 72'd1);
        RSTN = 1'b0;
        #1;
        check("mid_async_valid", 72'(OUT_VALID), 72'd0);
        check("mid_async_ovf", 72'(OVF), 72'd0);
        check("mid_async_data", 72'(OUT_DATA), 72'd0);
        check("mid_async_tag", 72'(OUT_TAG), 72'd0);
        tick();
        tick();
        EN = 1'b0;
        OUT_READY = 1'b1;
        RSTN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("mid_no_stale", 72'(OUT_VALID), 72'd0);
            tick();
        end
        load_vec(3);
        EN = 1'b1;
        tick();
        EN = 1'b0;
        tick();
        tick();
        check("mid_first_valid", 72'(OUT_VALID), 72'd1);
        check("mid_first_tag", 72'(OUT_TAG), 72'd0);
        check("mid_first_data", 72'(OUT_DATA), 72'(vecs[3].exp));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_sample_aligner.md
ADC_SAMPLE_ALIGNER -- requirements
Module: adc_sample_aligner

Interface
REQ-001 The module SHALL have parameter ADC_BITS, default 9, giving the sub-ADC code width (unsigned).
REQ-002 The module SHALL have parameter FIFO_DEPTH, default 4, giving the output frame FIFO depth (power of 2, at least 2).
REQ-003 The module SHALL have one clock and an asynchronous active-low reset:
  CLK  in  1  rising-edge clock, the 1/8-rate deserialized ADC clock; one frame per cycle.
  RSTN  in  1  asynchronous assert, active-low reset.
REQ-004 The module SHALL have these data-path ports:
  ADCIN0..ADCIN7  in  ADC_BITS each  sub-ADC codes; ADCIN0 is from sub-ADC 0.
  EN  in  1  capture enable, sampled each CLK.
  ROT  in  3  index of the sub-ADC that maps to output lane 0.
  OFS0..OFS7  in  8 each  signed two's-complement per-channel offset, indexed by sub-ADC.
  OUT_DATA  out  8*ADC_BITS  aligned frame; lane k in bits [k*ADC_BITS +: ADC_BITS].
  OUT_TAG  out  8  frame sequence number of the head frame.
  OUT_VALID  out  1  head frame available.
  OUT_READY  in  1  consumer accepts the head frame when high with OUT_VALID.
  OVF  out  1  sticky overflow flag.
  CLR_OVF  in  1  synchronous clear of OVF.

Function
REQ-005 Stage 1 SHALL register all ADCIN codes, ROT and the OFS values when EN=1, and set s1_valid=EN.
REQ-006 Stage 2 SHALL compute each corrected code as the ADCIN code minus its OFS value, in signed arithmetic at least ADC_BITS+2 bits wide.
REQ-007 Each corrected code SHALL saturate to the range 0..2^ADC_BITS-1; for example 3-5 gives 0, and 510-(-4) gives 511.
REQ-008 Output lane k SHALL carry corrected sub-ADC channel (ROT+k) mod 8, using the ROT value latched in stage 1.
REQ-009 The aligned frame SHALL be written to the FIFO at the end of stage 2, together with the 8-bit frame counter.
REQ-010 The frame counter SHALL increment once per stage-2-valid frame, whether the frame is stored or dropped, and SHALL wrap from 255 to 0.
REQ-011 Latency SHALL be 2 cycles: inputs sampled at edge N with the FIFO empty produce OUT_VALID=1 after edge N+2.
REQ-012 OUT_VALID SHALL be high whenever the FIFO is non-empty.
REQ-013 OUT_DATA and OUT_TAG SHALL reflect the head entry and SHALL hold stable while OUT_VALID=1 and OUT_READY=0.
REQ-014 A pop SHALL occur on a CLK edge where OUT_VALID=1 and OUT_READY=1.
REQ-015 Full FIFO with simultaneous pop and push: both SHALL occur and the occupancy SHALL be unchanged.
REQ-016 Empty FIFO with simultaneous push: the frame SHALL be stored and OUT_VALID SHALL go high after that edge (no bypass).
REQ-017 Full FIFO, push without pop: the new frame SHALL be dropped, the FIFO contents SHALL be unchanged, and OVF SHALL be set on that edge.
REQ-018 OVF SHALL remain set until a cycle with CLR_OVF=1 and no new overflow; if CLR_OVF and an overflow occur in the same cycle, OVF SHALL stay 1.
REQ-019 EN=0 SHALL stop new frames entering the pipeline; frames already in flight SHALL complete and the FIFO SHALL continue draining.
REQ-020 The FIFO pointers SHALL wrap modulo FIFO_DEPTH, and occupancy SHALL be tracked with one extra bit so that full and empty are distinguished.

Reset
REQ-021 RSTN=0 SHALL immediately and asynchronously clear the following to 0: both pipeline valid flags, the FIFO pointers and occupancy, the frame counter, OUT_VALID and OVF.
REQ-022 While RSTN=0, OUT_DATA and OUT_TAG SHALL read 0.
REQ-023 Reset SHALL discard any in-flight or queued frames.
REQ-024 After RSTN deasserts, the first frame sampled with EN=1 SHALL carry OUT_TAG=0.

Verification
REQ-025 Baseline: ROT=0, OFS=0, ADCINk=k*10, EN pulsed for 1 cycle, OUT_READY=1 -> one frame after 2 cycles with lanes 0,10,...,70 and OUT_TAG=0.
REQ-026 Rotation and saturation: ROT=5, OFS2=+8, ADCIN2=3, OFS7=-4, ADCIN7=510 -> lane 5 (sub-ADC 2) =0 and lane 2 (sub-ADC 7) =511.
REQ-027 Backpressure and overflow: EN=1 continuously, OUT_READY=0 -> after 4 frames are stored OVF=1 and the head frame holds tag 0; release OUT_READY -> tags 0,1,2,3 are popped, then continue with the next tag sampled after space freed (gap in tags).
REQ-028 Full with simultaneous push and pop: FIFO full, OUT_READY=1, EN=1 -> occupancy stays 4 every cycle, tags increment by 1 per cycle, and OVF does not newly set.
REQ-029 Reset mid-stream: assert RSTN=0 with 3 frames queued and 2 in flight -> OUT_VALID=0 and OVF=0 immediately; after release, the first tag is 0 and no stale frames appear.
REQ-030 CLR_OVF priority: CLR_OVF=1 in the same cycle as a drop -> OVF=1; CLR_OVF=1 in a cycle with no drop -> OVF=0 the next cycle.
